// File: rtl/reorder_buffer.sv
// Reorder buffer: circular in-order retirement queue. Allocates tags for
// dispatched instructions, captures CDB results, and retires one entry per
// cycle into the register file. A committed branch mispredict raises a
// rollback pulse and clears the whole buffer on the following edge.
module reorder_buffer #(
  parameter int ROB_SIZE = 16,
  parameter int TAG_W    = 5
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             en_signal_from_dispatcher,
  input  logic [4:0]       rd_from_dispatcher,
  input  logic             is_store_from_dispatcher,
  input  logic             is_branch_from_dispatcher,
  input  logic             pred_jump_from_dispatcher,
  output logic [TAG_W-1:0] alloc_tag_to_dispatcher,
  output logic             full_to_dispatcher,
  input  logic [TAG_W-1:0] Q1_from_dispatcher,
  input  logic [TAG_W-1:0] Q2_from_dispatcher,
  output logic             ready1_to_dispatcher,
  output logic             ready2_to_dispatcher,
  output logic [31:0]      V1_to_dispatcher,
  output logic [31:0]      V2_to_dispatcher,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_value,
  input  logic             cdb_jump,
  input  logic [31:0]      cdb_target_pc,
  output logic             commit_flag_to_regfile,
  output logic [4:0]       rd_to_regfile,
  output logic [TAG_W-1:0] Q_to_regfile,
  output logic [31:0]      V_to_regfile,
  output logic             store_commit_to_lsb,
  output logic             rollback_flag,
  output logic [31:0]      target_pc_to_fetcher
);

  localparam int IDX_W = (ROB_SIZE > 1) ? $clog2(ROB_SIZE) : 1;

  // Entry storage
  logic             r_busy     [ROB_SIZE];
  logic             r_ready    [ROB_SIZE];
  logic [4:0]       r_rd       [ROB_SIZE];
  logic             r_is_store [ROB_SIZE];
  logic             r_is_br    [ROB_SIZE];
  logic             r_pred     [ROB_SIZE];
  logic             r_jump     [ROB_SIZE];
  logic [31:0]      r_value    [ROB_SIZE];
  logic [31:0]      r_target   [ROB_SIZE];
  logic [TAG_W-1:0] r_last_writer [32];

  logic [IDX_W-1:0] r_head;
  logic [IDX_W-1:0] r_tail;
  logic [TAG_W-1:0] r_count;
  logic             r_rb_pend;  // flush the whole buffer on the next active edge
  logic             r_squash;   // cycle after the flush: inputs are discarded

  logic             w_full;
  logic             w_block;
  logic             w_alloc;
  logic             w_commit;
  logic             w_cdb_hit;
  logic [IDX_W-1:0] w_cdb_idx;
  logic [TAG_W-1:0] w_head_tag;
  logic [TAG_W-1:0] w_tail_tag;
  logic [4:0]       w_cm_rd;
  logic             w_cm_write;
  logic             w_cm_mispred;
  logic [TAG_W-1:0] w_cm_q;
  logic [32:0]      w_probe1;
  logic [32:0]      w_probe2;

  function automatic logic [IDX_W-1:0] f_next(input logic [IDX_W-1:0] p);
    if (p == IDX_W'(ROB_SIZE - 1)) return '0;
    else                           return p + IDX_W'(1'b1);
  endfunction

  // Probe result {ready, value}; a live CDB broadcast is forwarded ahead of storage.
  function automatic logic [32:0] f_probe(input logic [TAG_W-1:0] q);
    logic [IDX_W-1:0] idx;
    logic [32:0]      res;
    idx = IDX_W'(q - TAG_W'(1'b1));
    res = 33'd0;
    if ((q != '0) && (q <= TAG_W'(ROB_SIZE))) begin
      if (cdb_valid && (cdb_tag == q))          res = {1'b1, cdb_value};
      else if (r_busy[idx] && r_ready[idx])    res = {1'b1, r_value[idx]};
      else                                     res = 33'd0;
    end else begin
      res = 33'd0;
    end
    return res;
  endfunction

  assign w_full     = (r_count == TAG_W'(ROB_SIZE));
  assign w_block    = !rdy_in || r_rb_pend || r_squash;
  assign w_head_tag = TAG_W'(r_head) + TAG_W'(1'b1);
  assign w_tail_tag = TAG_W'(r_tail) + TAG_W'(1'b1);
  assign w_cdb_idx  = IDX_W'(cdb_tag - TAG_W'(1'b1));
  assign w_cm_rd    = r_rd[r_head];

  assign alloc_tag_to_dispatcher = w_tail_tag;
  assign full_to_dispatcher      = w_full;

  // Decide allocation, capture and commit for this cycle and the commit Q tag.
  always_comb begin
    w_alloc      = en_signal_from_dispatcher && !w_full && !w_block;
    w_commit     = (r_count != '0) && r_busy[r_head] && r_ready[r_head] && !w_block;
    w_cdb_hit    = cdb_valid && (cdb_tag != '0) && (cdb_tag <= TAG_W'(ROB_SIZE))
                   && r_busy[w_cdb_idx] && !w_block;
    w_cm_write   = !r_is_store[r_head] && (w_cm_rd != 5'd0);
    w_cm_mispred = r_is_br[r_head] && (r_jump[r_head] != r_pred[r_head]);
    if (w_alloc && (rd_from_dispatcher == w_cm_rd)) begin
      w_cm_q = w_tail_tag;
    end else if (r_last_writer[w_cm_rd] == w_head_tag) begin
      w_cm_q = '0;
    end else begin
      w_cm_q = r_last_writer[w_cm_rd];
    end
  end

  // Combinational operand probes for the dispatcher.
  always_comb begin
    w_probe1             = f_probe(Q1_from_dispatcher);
    w_probe2             = f_probe(Q2_from_dispatcher);
    ready1_to_dispatcher = w_probe1[32];
    V1_to_dispatcher     = w_probe1[31:0];
    ready2_to_dispatcher = w_probe2[32];
    V2_to_dispatcher     = w_probe2[31:0];
  end

  // Buffer state, retirement and registered pulse outputs.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < ROB_SIZE; i++) begin
        r_busy[i] <= 1'b0; r_ready[i] <= 1'b0; r_rd[i] <= 5'd0;
        r_is_store[i] <= 1'b0; r_is_br[i] <= 1'b0; r_pred[i] <= 1'b0;
        r_jump[i] <= 1'b0; r_value[i] <= 32'd0; r_target[i] <= 32'd0;
      end
      for (int i = 0; i < 32; i++) r_last_writer[i] <= '0;
      r_head <= '0; r_tail <= '0; r_count <= '0;
      r_rb_pend <= 1'b0; r_squash <= 1'b0;
      commit_flag_to_regfile <= 1'b0; rd_to_regfile <= 5'd0;
      Q_to_regfile <= '0; V_to_regfile <= 32'd0;
      store_commit_to_lsb <= 1'b0; rollback_flag <= 1'b0;
      target_pc_to_fetcher <= 32'd0;
    end else begin
      commit_flag_to_regfile <= 1'b0; rd_to_regfile <= 5'd0;
      Q_to_regfile <= '0; V_to_regfile <= 32'd0;
      store_commit_to_lsb <= 1'b0; rollback_flag <= 1'b0;
      target_pc_to_fetcher <= 32'd0;
      if (rdy_in) begin
        if (r_rb_pend) begin
          for (int i = 0; i < ROB_SIZE; i++) begin
            r_busy[i] <= 1'b0; r_ready[i] <= 1'b0;
          end
          for (int i = 0; i < 32; i++) r_last_writer[i] <= '0;
          r_head <= '0; r_tail <= '0; r_count <= '0;
          r_rb_pend <= 1'b0; r_squash <= 1'b1;
        end else if (r_squash) begin
          r_squash <= 1'b0;
        end else begin
          if (w_cdb_hit) begin
            r_ready[w_cdb_idx]  <= 1'b1;
            r_value[w_cdb_idx]  <= cdb_value;
            r_jump[w_cdb_idx]   <= cdb_jump;
            r_target[w_cdb_idx] <= cdb_target_pc;
          end
          if (w_commit) begin
            r_busy[r_head] <= 1'b0;
            r_head         <= f_next(r_head);
            if (w_cm_write) begin
              commit_flag_to_regfile <= 1'b1;
              rd_to_regfile          <= w_cm_rd;
              Q_to_regfile           <= w_cm_q;
              V_to_regfile           <= r_value[r_head];
              if (w_cm_q == '0) r_last_writer[w_cm_rd] <= '0;
            end
            if (r_is_store[r_head]) store_commit_to_lsb <= 1'b1;
            if (w_cm_mispred) begin
              rollback_flag        <= 1'b1;
              target_pc_to_fetcher <= r_target[r_head];
              r_rb_pend            <= 1'b1;
            end
          end
          // Allocation comes after commit so a same-rd allocation wins last_writer.
          if (w_alloc) begin
            r_busy[r_tail]     <= 1'b1;
            r_ready[r_tail]    <= 1'b0;
            r_rd[r_tail]       <= rd_from_dispatcher;
            r_is_store[r_tail] <= is_store_from_dispatcher;
            r_is_br[r_tail]    <= is_branch_from_dispatcher;
            r_pred[r_tail]     <= pred_jump_from_dispatcher;
            r_tail             <= f_next(r_tail);
            if (rd_from_dispatcher != 5'd0) r_last_writer[rd_from_dispatcher] <= w_tail_tag;
          end
          case ({w_alloc, w_commit})
            2'b10:   r_count <= r_count + TAG_W'(1'b1);
            2'b01:   r_count <= r_count - TAG_W'(1'b1);
            default: r_count <= r_count;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer with a scoreboard of expected retirements.
module tb_reorder_buffer;

  typedef struct packed {
    logic        cf;
    logic        st;
    logic        rb;
    logic [4:0]  rd;
    logic [4:0]  q;
    logic [31:0] v;
    logic [31:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, rdy, en, st_d, br_d, pred_d;
  logic [4:0]  rd_d, alloc_tag, q1, q2, cdb_t, rdo, qo;
  logic        full, ready1, ready2, cdb_v, cdb_j, cf, stc, rb;
  logic [31:0] v1, v2, cdb_val, cdb_pc, vo, tpc;

  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  exp_t exp_q[$];
  int   pop_cyc[$];

  always #5 clk = ~clk;

  reorder_buffer dut (
    .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy),
    .en_signal_from_dispatcher(en), .rd_from_dispatcher(rd_d),
    .is_store_from_dispatcher(st_d), .is_branch_from_dispatcher(br_d),
    .pred_jump_from_dispatcher(pred_d), .alloc_tag_to_dispatcher(alloc_tag),
    .full_to_dispatcher(full), .Q1_from_dispatcher(q1), .Q2_from_dispatcher(q2),
    .ready1_to_dispatcher(ready1), .ready2_to_dispatcher(ready2),
    .V1_to_dispatcher(v1), .V2_to_dispatcher(v2),
    .cdb_valid(cdb_v), .cdb_tag(cdb_t), .cdb_value(cdb_val), .cdb_jump(cdb_j),
    .cdb_target_pc(cdb_pc), .commit_flag_to_regfile(cf), .rd_to_regfile(rdo),
    .Q_to_regfile(qo), .V_to_regfile(vo), .store_commit_to_lsb(stc),
    .rollback_flag(rb), .target_pc_to_fetcher(tpc)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic c, input logic s, input logic r, input logic [4:0] rdv,
                          input logic [4:0] qv, input logic [31:0] vv, input logic [31:0] pcv);
    exp_t e;
    e = '{cf: c, st: s, rb: r, rd: rdv, q: qv, v: vv, pc: pcv};
    exp_q.push_back(e);
  endtask

  // One negedge sample of the retirement pulses against the scoreboard.
  task automatic monitor_step();
    exp_t e;
    if (cf || stc || rb) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {29'd0, cf, stc, rb}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        pop_cyc.push_back(cyc);
        check("pulse_kind", {29'd0, cf, stc, rb}, {29'd0, e.cf, e.st, e.rb});
        if (e.cf) begin
          check("commit_rd", {27'd0, rdo}, {27'd0, e.rd});
          check("commit_q",  {27'd0, qo},  {27'd0, e.q});
          check("commit_v",  vo, e.v);
        end
        if (e.rb) check("rollback_pc", tpc, e.pc);
      end
    end
  endtask

  task automatic dispatch(input logic [4:0] rdv, input logic s, input logic b, input logic p);
    en = 1'b1; rd_d = rdv; st_d = s; br_d = b; pred_d = p;
    tick();
    en = 1'b0; rd_d = 5'd0; st_d = 1'b0; br_d = 1'b0; pred_d = 1'b0;
  endtask

  task automatic cdb_send(input logic [4:0] t, input logic [31:0] v, input logic j, input logic [31:0] pc);
    cdb_v = 1'b1; cdb_t = t; cdb_val = v; cdb_j = j; cdb_pc = pc;
    tick();
    cdb_v = 1'b0; cdb_t = 5'd0; cdb_val = 32'd0; cdb_j = 1'b0; cdb_pc = 32'd0;
  endtask

  task automatic wait_q(input string tag, input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() <= n) break;
      @(negedge clk);
      #2;
    end
    check(tag, 32'(exp_q.size()), 32'(n));
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; cdb_v = 1'b0; q1 = 5'd0; q2 = 5'd0;
    repeat (2) tick();
    exp_q.delete();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_cf"},  {31'd0, cf}, 32'd0);
    check({tag, "_rd"},  {27'd0, rdo}, 32'd0);
    check({tag, "_q"},   {27'd0, qo}, 32'd0);
    check({tag, "_v"},   vo, 32'd0);
    check({tag, "_st"},  {31'd0, stc}, 32'd0);
    check({tag, "_rb"},  {31'd0, rb}, 32'd0);
    check({tag, "_tpc"}, tpc, 32'd0);
    check({tag, "_full"}, {31'd0, full}, 32'd0);
    check({tag, "_tag"}, {27'd0, alloc_tag}, 32'd1);
  endtask

  initial begin
    int found;
    rst_n = 1'b0; rdy = 1'b1; en = 1'b0; rd_d = 5'd0; st_d = 1'b0; br_d = 1'b0;
    pred_d = 1'b0; q1 = 5'd0; q2 = 5'd0; cdb_v = 1'b0; cdb_t = 5'd0;
    cdb_val = 32'd0; cdb_j = 1'b0; cdb_pc = 32'd0;
    fork
      forever begin @(posedge clk); cyc++; end
      forever begin @(negedge clk); monitor_step(); end
      begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
      end
    join_none

    // Reset state and single commit
    repeat (2) tick();
    check_outputs_zero("reset");
    rst_n = 1'b1;
    tick();
    dispatch(5'd5, 1'b0, 1'b0, 1'b0);
    check("t1_tag_after", {27'd0, alloc_tag}, 32'd2);
    push_exp(1'b1, 1'b0, 1'b0, 5'd5, 5'd0, 32'h1234, 32'd0);
    cdb_send(5'd1, 32'h1234, 1'b0, 32'd0);
    wait_q("t1_drain", 0, 10);

    // Same rd twice: older commit leaves Q pointing at the younger tag
    do_reset();
    dispatch(5'd3, 1'b0, 1'b0, 1'b0);
    dispatch(5'd3, 1'b0, 1'b0, 1'b0);
    push_exp(1'b1, 1'b0, 1'b0, 5'd3, 5'd2, 32'hA0A0, 32'd0);
    push_exp(1'b1, 1'b0, 1'b0, 5'd3, 5'd0, 32'hB0B0, 32'd0);
    cdb_send(5'd1, 32'hA0A0, 1'b0, 32'd0);
    wait_q("t2_first", 1, 10);
    cdb_send(5'd2, 32'hB0B0, 1'b0, 32'd0);
    wait_q("t2_second", 0, 10);

    // Same-cycle allocation to the committing rd wins the Q tag
    do_reset();
    dispatch(5'd7, 1'b0, 1'b0, 1'b0);
    push_exp(1'b1, 1'b0, 1'b0, 5'd7, 5'd2, 32'hAA, 32'd0);
    push_exp(1'b1, 1'b0, 1'b0, 5'd7, 5'd0, 32'hBB, 32'd0);
    cdb_send(5'd1, 32'hAA, 1'b0, 32'd0);
    dispatch(5'd7, 1'b0, 1'b0, 1'b0);
    check("t2b_tag", {27'd0, alloc_tag}, 32'd3);
    cdb_send(5'd2, 32'hBB, 1'b0, 32'd0);
    wait_q("t2b_drain", 0, 10);
    check("t2b_store", {31'd0, stc}, 32'd0);

    // Fill, overflow attempt, wrap-around
    do_reset();
    for (int i = 0; i < 16; i++) begin
      dispatch(5'(i + 1), 1'b0, 1'b0, 1'b0);
      push_exp(1'b1, 1'b0, 1'b0, 5'(i + 1), 5'd0, 32'h100 + 32'(i), 32'd0);
    end
    check("t3_full", {31'd0, full}, 32'd1);
    check("t3_wrap_tag", {27'd0, alloc_tag}, 32'd1);
    dispatch(5'd30, 1'b0, 1'b0, 1'b0);
    check("t3_ovf_tag", {27'd0, alloc_tag}, 32'd1);
    check("t3_ovf_full", {31'd0, full}, 32'd1);
    cdb_send(5'd1, 32'h100, 1'b0, 32'd0);
    wait_q("t3_first", 15, 10);
    check("t3_notfull", {31'd0, full}, 32'd0);
    dispatch(5'd20, 1'b0, 1'b0, 1'b0);
    push_exp(1'b1, 1'b0, 1'b0, 5'd20, 5'd0, 32'h500, 32'd0);
    check("t3_refull", {31'd0, full}, 32'd1);
    check("t3_tag2", {27'd0, alloc_tag}, 32'd2);
    for (int i = 1; i < 16; i++) cdb_send(5'(i + 1), 32'h100 + 32'(i), 1'b0, 32'd0);
    cdb_send(5'd1, 32'h500, 1'b0, 32'd0);
    wait_q("t3_drain", 0, 60);

    // Out-of-order completion retires in order on consecutive cycles
    do_reset();
    pop_cyc.delete();
    for (int i = 0; i < 3; i++) begin
      dispatch(5'(10 + i), 1'b0, 1'b0, 1'b0);
      push_exp(1'b1, 1'b0, 1'b0, 5'(10 + i), 5'd0, 32'h30 + 32'(i), 32'd0);
    end
    cdb_send(5'd3, 32'h32, 1'b0, 32'd0);
    cdb_send(5'd2, 32'h31, 1'b0, 32'd0);
    cdb_send(5'd1, 32'h30, 1'b0, 32'd0);
    wait_q("t4_drain", 0, 10);
    if (pop_cyc.size() == 3) begin
      check("t4_gap01", 32'(pop_cyc[1] - pop_cyc[0]), 32'd1);
      check("t4_gap12", 32'(pop_cyc[2] - pop_cyc[1]), 32'd1);
    end else begin
      check("t4_pops", 32'(pop_cyc.size()), 32'd3);
    end

    // Store then mispredicted branch: rollback squashes younger entries
    do_reset();
    dispatch(5'd0, 1'b1, 1'b0, 1'b0);
    push_exp(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0);
    dispatch(5'd0, 1'b0, 1'b1, 1'b0);
    dispatch(5'd8, 1'b0, 1'b0, 1'b0);
    push_exp(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 32'd0, 32'h100);
    cdb_send(5'd3, 32'h55, 1'b0, 32'd0);
    cdb_send(5'd1, 32'd0, 1'b0, 32'd0);
    cdb_send(5'd2, 32'd0, 1'b1, 32'h100);
    found = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rb) begin found = 1; break; end
    end
    check("t5_rollback_seen", 32'(found), 32'd1);
    tick();
    check("t5_tag_after", {27'd0, alloc_tag}, 32'd1);
    check("t5_full_after", {31'd0, full}, 32'd0);
    repeat (6) tick();
    wait_q("t5_drain", 0, 2);
    dispatch(5'd4, 1'b0, 1'b0, 1'b0);
    push_exp(1'b1, 1'b0, 1'b0, 5'd4, 5'd0, 32'h44, 32'd0);
    cdb_send(5'd1, 32'h44, 1'b0, 32'd0);
    wait_q("t5_restart", 0, 10);

    // Operand probe with CDB forwarding, then reset mid-stream
    do_reset();
    dispatch(5'd9, 1'b0, 1'b0, 1'b0);
    dispatch(5'd9, 1'b0, 1'b0, 1'b0);
    q1 = 5'd2; q2 = 5'd1;
    @(negedge clk);
    check("t6_r1_idle", {31'd0, ready1}, 32'd0);
    check("t6_v1_idle", v1, 32'd0);
    tick();
    cdb_v = 1'b1; cdb_t = 5'd2; cdb_val = 32'd7;
    @(negedge clk);
    check("t6_r1_fwd", {31'd0, ready1}, 32'd1);
    check("t6_v1_fwd", v1, 32'd7);
    check("t6_r2_fwd", {31'd0, ready2}, 32'd0);
    tick();
    cdb_v = 1'b0; cdb_t = 5'd0; cdb_val = 32'd0;
    @(negedge clk);
    check("t6_r1_stored", {31'd0, ready1}, 32'd1);
    check("t6_v1_stored", v1, 32'd7);
    q1 = 5'd0;
    #1;
    check("t6_r1_q0", {31'd0, ready1}, 32'd0);
    check("t6_v1_q0", v1, 32'd0);
    q2 = 5'd0;
    tick();
    push_exp(1'b1, 1'b0, 1'b0, 5'd9, 5'd2, 32'd5, 32'd0);
    push_exp(1'b1, 1'b0, 1'b0, 5'd9, 5'd0, 32'd7, 32'd0);
    cdb_send(5'd1, 32'd5, 1'b0, 32'd0);
    wait_q("t6_first", 1, 10);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("t6_midreset");
    exp_q.delete();
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    check("t6_quiet", {29'd0, cf, stc, rb}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
